// File: rtl/gated_integrator_ctrl.sv
// Sequencer for one gated integrator channel: cfg check, delay-RAM zero-fill, accumulator load, per-sample addressing.
// Latency: every output is registered one cycle after the input that causes it; cfg_ready is decoded from state only.
// Backpressure: cfg_ready is low during CLEAR/LOAD so the requester holds cfg; samples that cannot be taken pulse s_drop.
module gated_integrator_ctrl #(
    parameter int P_NBITS_DATA_OUT     = 24,
    parameter int P_NBITS_DELAY_A_ADDR = 9,
    parameter int P_NBITS_DELAY_B_ADDR = 14,
    parameter int P_RD_LEAD            = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [P_NBITS_DELAY_A_ADDR-1:0] cfg_len_a,
    input  logic [P_NBITS_DELAY_B_ADDR-1:0] cfg_len_b,
    input  logic [P_NBITS_DATA_OUT-1:0]     cfg_init_y,
    output logic                            cfg_err,
    input  logic                            s_valid,
    output logic                            s_drop,
    output logic                            gi_wr,
    output logic                            gi_init_wr,
    output logic [P_NBITS_DATA_OUT-1:0]     gi_init_y,
    output logic                            clr_active,
    output logic                            a_we,
    output logic                            b_we,
    output logic [P_NBITS_DELAY_A_ADDR-1:0] a_waddr,
    output logic [P_NBITS_DELAY_A_ADDR-1:0] a_raddr,
    output logic [P_NBITS_DELAY_B_ADDR-1:0] b_waddr,
    output logic [P_NBITS_DELAY_B_ADDR-1:0] b_raddr,
    output logic                            running
);
    localparam int NA   = P_NBITS_DELAY_A_ADDR;
    localparam int NB   = P_NBITS_DELAY_B_ADDR;
    localparam int NOUT = P_NBITS_DATA_OUT;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [NA-1:0]     len_a_q, len_a_d;
    logic [NB-1:0]     len_b_q, len_b_d;
    logic [NOUT-1:0]   init_y_q, init_y_d;
    logic [NB-1:0]     cnt_q, cnt_d;
    logic [NA-1:0]     wa_q, wa_d, ra_q, ra_d;
    logic [NB-1:0]     wb_q, wb_d, rb_q, rb_d;

    logic              cfg_err_q, cfg_err_d, s_drop_q, s_drop_d;
    logic              gi_wr_q, gi_wr_d, gi_init_wr_q, gi_init_wr_d;
    logic [NOUT-1:0]   gi_init_y_q, gi_init_y_d;
    logic              clr_active_q, clr_active_d, running_q, running_d;
    logic              a_we_q, a_we_d, b_we_q, b_we_d;
    logic [NA-1:0]     a_waddr_q, a_waddr_d, a_raddr_q, a_raddr_d;
    logic [NB-1:0]     b_waddr_q, b_waddr_d, b_raddr_q, b_raddr_d;

    logic              cfg_take, cfg_ok, cfg_go;

    function automatic logic [NA-1:0] wrap_a(input logic [NA-1:0] p, input logic [NA-1:0] len);
        return (p == len - 1'b1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [NB-1:0] wrap_b(input logic [NB-1:0] p, input logic [NB-1:0] len);
        return (p == len - 1'b1) ? '0 : p + 1'b1;
    endfunction

    // Handshake is state-only so the register bank sees no path from its own cfg_valid.
    assign cfg_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    assign cfg_take  = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_len_a >= NA'(P_RD_LEAD + 1)) && (cfg_len_b > NB'(cfg_len_a));
    assign cfg_go    = cfg_take && cfg_ok;

    // Next-state, config latching, pointer advance and registered-output values.
    always_comb begin
        state_d      = state_q;
        len_a_d      = len_a_q;
        len_b_d      = len_b_q;
        init_y_d     = init_y_q;
        cnt_d        = cnt_q;
        wa_d         = wa_q;
        ra_d         = ra_q;
        wb_d         = wb_q;
        rb_d         = rb_q;
        cfg_err_d    = cfg_take && !cfg_ok;
        // A valid cfg in RUN pre-empts a same-cycle sample.
        s_drop_d     = s_valid && !((state_q == S_RUN) && !cfg_go);
        gi_wr_d      = 1'b0;
        gi_init_wr_d = 1'b0;
        gi_init_y_d  = gi_init_y_q;
        clr_active_d = 1'b0;
        a_we_d       = 1'b0;
        b_we_d       = 1'b0;
        a_waddr_d    = a_waddr_q;
        a_raddr_d    = a_raddr_q;
        b_waddr_d    = b_waddr_q;
        b_raddr_d    = b_raddr_q;

        if (cfg_go) begin
            // First clear address (c=0) goes out with the CLEAR state itself; len_a >= 1 always here.
            len_a_d      = cfg_len_a;
            len_b_d      = cfg_len_b;
            init_y_d     = cfg_init_y;
            state_d      = S_CLEAR;
            cnt_d        = NB'(1);
            clr_active_d = 1'b1;
            a_we_d       = 1'b1;
            b_we_d       = 1'b1;
            a_waddr_d    = '0;
            b_waddr_d    = '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (cnt_q < len_b_q) begin
                        clr_active_d = 1'b1;
                        a_we_d       = (cnt_q < NB'(len_a_q));
                        b_we_d       = 1'b1;
                        a_waddr_d    = cnt_q[NA-1:0];
                        b_waddr_d    = cnt_q;
                        cnt_d        = cnt_q + 1'b1;
                    end else begin
                        state_d      = S_LOAD;
                        gi_init_wr_d = 1'b1;
                        gi_init_y_d  = init_y_q;
                        wa_d         = '0;
                        wb_d         = '0;
                        ra_d         = NA'(P_RD_LEAD);
                        rb_d         = NB'(P_RD_LEAD);
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (s_valid) begin
                        gi_wr_d   = 1'b1;
                        a_we_d    = 1'b1;
                        b_we_d    = 1'b1;
                        a_waddr_d = wa_q;
                        a_raddr_d = ra_q;
                        b_waddr_d = wb_q;
                        b_raddr_d = rb_q;
                        wa_d      = wrap_a(wa_q, len_a_q);
                        ra_d      = wrap_a(ra_q, len_a_q);
                        wb_d      = wrap_b(wb_q, len_b_q);
                        rb_d      = wrap_b(rb_q, len_b_q);
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == S_RUN);
    end

    // State, config and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_a_q      <= '0;
            len_b_q      <= '0;
            init_y_q     <= '0;
            cnt_q        <= '0;
            wa_q         <= '0;
            ra_q         <= '0;
            wb_q         <= '0;
            rb_q         <= '0;
            cfg_err_q    <= 1'b0;
            s_drop_q     <= 1'b0;
            gi_wr_q      <= 1'b0;
            gi_init_wr_q <= 1'b0;
            gi_init_y_q  <= '0;
            clr_active_q <= 1'b0;
            running_q    <= 1'b0;
            a_we_q       <= 1'b0;
            b_we_q       <= 1'b0;
            a_waddr_q    <= '0;
            a_raddr_q    <= '0;
            b_waddr_q    <= '0;
            b_raddr_q    <= '0;
        end else begin
            state_q      <= state_d;
            len_a_q      <= len_a_d;
            len_b_q      <= len_b_d;
            init_y_q     <= init_y_d;
            cnt_q        <= cnt_d;
            wa_q         <= wa_d;
            ra_q         <= ra_d;
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            cfg_err_q    <= cfg_err_d;
            s_drop_q     <= s_drop_d;
            gi_wr_q      <= gi_wr_d;
            gi_init_wr_q <= gi_init_wr_d;
            gi_init_y_q  <= gi_init_y_d;
            clr_active_q <= clr_active_d;
            running_q    <= running_d;
            a_we_q       <= a_we_d;
            b_we_q       <= b_we_d;
            a_waddr_q    <= a_waddr_d;
            a_raddr_q    <= a_raddr_d;
            b_waddr_q    <= b_waddr_d;
            b_raddr_q    <= b_raddr_d;
        end
    end

    assign cfg_err    = cfg_err_q;
    assign s_drop     = s_drop_q;
    assign gi_wr      = gi_wr_q;
    assign gi_init_wr = gi_init_wr_q;
    assign gi_init_y  = gi_init_y_q;
    assign clr_active = clr_active_q;
    assign running    = running_q;
    assign a_we       = a_we_q;
    assign b_we       = b_we_q;
    assign a_waddr    = a_waddr_q;
    assign a_raddr    = a_raddr_q;
    assign b_waddr    = b_waddr_q;
    assign b_raddr    = b_raddr_q;
endmodule

// File: tb/tb_gated_integrator_ctrl.sv
// Bench for gated_integrator_ctrl: directed cfg/sample vectors against a sample-count model.
// Model is updated on each rising edge; outputs are compared 1 time unit later.
// Literal expectations pin the clear length, address sequences and reset behaviour.
module tb_gated_integrator_ctrl;
    localparam int NA = 9, NB = 14, NOUT = 24, LEAD = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [NA-1:0]   cfg_len_a = '0;
    logic [NB-1:0]   cfg_len_b = '0;
    logic [NOUT-1:0] cfg_init_y = '0;
    logic            s_valid = 1'b0;
    logic            cfg_ready, cfg_err, s_drop, gi_wr, gi_init_wr, clr_active;
    logic            a_we, b_we, running;
    logic [NOUT-1:0] gi_init_y;
    logic [NA-1:0]   a_waddr, a_raddr;
    logic [NB-1:0]   b_waddr, b_raddr;

    gated_integrator_ctrl #(
        .P_NBITS_DATA_OUT(NOUT), .P_NBITS_DELAY_A_ADDR(NA),
        .P_NBITS_DELAY_B_ADDR(NB), .P_RD_LEAD(LEAD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_len_a(cfg_len_a), .cfg_len_b(cfg_len_b), .cfg_init_y(cfg_init_y),
        .cfg_err(cfg_err), .s_valid(s_valid), .s_drop(s_drop), .gi_wr(gi_wr),
        .gi_init_wr(gi_init_wr), .gi_init_y(gi_init_y), .clr_active(clr_active),
        .a_we(a_we), .b_we(b_we), .a_waddr(a_waddr), .a_raddr(a_raddr),
        .b_waddr(b_waddr), .b_raddr(b_raddr), .running(running)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 clear, 2 load, 3 run; addresses from sample count modulo length.
    int m_ph = 0, m_la = 0, m_lb = 0, m_init = 0, m_c = 0, m_n = 0;
    bit e_awe, e_bwe, e_gwr, e_giw, e_clr, e_run, e_err, e_drop, e_rdy;
    int e_aw, e_ar, e_bw, e_br, e_iy;
    bit m_ok, m_take, m_go;

    always @(posedge clk) begin
        e_awe = 0; e_bwe = 0; e_gwr = 0; e_giw = 0; e_clr = 0; e_err = 0; e_drop = 0;
        e_aw = 0; e_ar = 0; e_bw = 0; e_br = 0; e_iy = 0;
        if (!rst_n) begin
            m_ph = 0; m_la = 0; m_lb = 0; m_init = 0;
        end else begin
            m_ok   = (int'(cfg_len_a) >= LEAD + 1) && (int'(cfg_len_b) > int'(cfg_len_a));
            m_take = cfg_valid && (m_ph == 0 || m_ph == 3);
            m_go   = m_take && m_ok;
            e_err  = m_take && !m_ok;
            e_drop = s_valid && !(m_ph == 3 && !m_go);
            if (m_go) begin
                m_la = int'(cfg_len_a); m_lb = int'(cfg_len_b); m_init = int'(cfg_init_y);
                m_ph = 1; m_c = 0;
            end else if (m_ph == 2) begin
                m_ph = 3; m_n = 0;
            end else if (m_ph == 1 && m_c >= m_lb) begin
                m_ph = 2;
                e_giw = 1; e_iy = m_init;
            end else if (m_ph == 3 && s_valid) begin
                e_gwr = 1; e_awe = 1; e_bwe = 1;
                e_aw = m_n % m_la; e_ar = (m_n + LEAD) % m_la;
                e_bw = m_n % m_lb; e_br = (m_n + LEAD) % m_lb;
                m_n++;
            end
            if (m_ph == 1 && m_c < m_lb) begin
                e_clr = 1; e_awe = (m_c < m_la); e_bwe = 1; e_aw = m_c; e_bw = m_c;
                m_c++;
            end
        end
        e_run = (m_ph == 3);
        e_rdy = (m_ph == 0 || m_ph == 3);
    end

    bit cmp_en = 0;
    int clr_cnt = 0, clr_awe_cnt = 0, init_cnt = 0, gwr_cnt = 0, err_cnt = 0, drop_cnt = 0;
    int qaw[$], qar[$], qbw[$];

    // Cycle-by-cycle comparison against the model, plus event tallies for literal checks.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("a_we", a_we, e_awe);
            chk("b_we", b_we, e_bwe);
            chk("gi_wr", gi_wr, e_gwr);
            chk("gi_init_wr", gi_init_wr, e_giw);
            chk("clr_active", clr_active, e_clr);
            chk("running", running, e_run);
            chk("cfg_err", cfg_err, e_err);
            chk("s_drop", s_drop, e_drop);
            chk("cfg_ready", cfg_ready, e_rdy);
            if (e_awe) chk("a_waddr", int'(a_waddr), e_aw % (1 << NA));
            if (e_bwe) chk("b_waddr", int'(b_waddr), e_bw);
            if (e_gwr) begin
                chk("a_raddr", int'(a_raddr), e_ar);
                chk("b_raddr", int'(b_raddr), e_br);
            end
            if (e_giw) chk("gi_init_y", int'(gi_init_y), e_iy);
        end
        if (clr_active) clr_cnt++;
        if (clr_active && a_we) clr_awe_cnt++;
        if (gi_init_wr) init_cnt++;
        if (cfg_err) err_cnt++;
        if (s_drop) drop_cnt++;
        if (gi_wr) begin
            gwr_cnt++;
            qaw.push_back(int'(a_waddr));
            qar.push_back(int'(a_raddr));
            qbw.push_back(int'(b_waddr));
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_cfg(input int la, input int lb, input int iy);
        cfg_len_a = NA'(la); cfg_len_b = NB'(lb); cfg_init_y = NOUT'(iy);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int exp_aw[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        int exp_ar[10] = '{2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        int exp_bw[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

        // Reset held for 3 cycles
        cyc(1);
        cmp_en = 1;
        cyc(2);
        chk("rst a_we", a_we, 0);
        chk("rst gi_wr", gi_wr, 0);
        chk("rst clr_active", clr_active, 0);
        chk("rst a_waddr", int'(a_waddr), 0);
        chk("rst cfg_ready", cfg_ready, 1);
        chk("rst running", running, 0);
        rst_n = 1'b1;
        cyc(2);

        // Valid cfg: 8-cycle clear, a_we on first 4, one init load
        clr_cnt = 0; clr_awe_cnt = 0; init_cnt = 0;
        send_cfg(4, 8, 'h000100);
        cyc(12);
        chk("clear cycles", clr_cnt, 8);
        chk("clear a_we cycles", clr_awe_cnt, 4);
        chk("init loads", init_cnt, 1);
        chk("running after load", running, 1);

        // 10 back-to-back samples
        gwr_cnt = 0; qaw.delete(); qar.delete(); qbw.delete();
        s_valid = 1'b1;
        cyc(10);
        s_valid = 1'b0;
        cyc(2);
        chk("gi_wr count", gwr_cnt, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("a_waddr[%0d]", i), (i < qaw.size()) ? qaw[i] : -1, exp_aw[i]);
            chk($sformatf("a_raddr[%0d]", i), (i < qar.size()) ? qar[i] : -1, exp_ar[i]);
            chk($sformatf("b_waddr[%0d]", i), (i < qbw.size()) ? qbw[i] : -1, exp_bw[i]);
        end

        // Rejected cfgs leave RUN and lengths alone
        err_cnt = 0;
        send_cfg(2, 8, 'h123);
        cyc(2);
        send_cfg(6, 6, 'h456);
        cyc(2);
        chk("cfg_err pulses", err_cnt, 2);
        chk("running after reject", running, 1);
        qaw.delete(); qbw.delete();
        s_valid = 1'b1;
        cyc(2);
        s_valid = 1'b0;
        cyc(1);
        chk("a_waddr continues", (qaw.size() > 0) ? qaw[0] : -1, 2);
        chk("b_waddr continues", (qbw.size() > 0) ? qbw[0] : -1, 2);

        // cfg and sample together: cfg wins; samples during clear are dropped
        drop_cnt = 0;
        cfg_len_a = NA'(3); cfg_len_b = NB'(5); cfg_init_y = NOUT'('hABCDEF);
        cfg_valid = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("collide s_drop", s_drop, 1);
        chk("collide gi_wr", gi_wr, 0);
        chk("collide clr_active", clr_active, 1);
        cyc(4);
        s_valid = 1'b0;
        cyc(2);
        chk("drop count", drop_cnt, 5);
        cyc(3);
        qaw.delete(); qar.delete();
        s_valid = 1'b1;
        cyc(3);
        s_valid = 1'b0;
        cyc(1);
        chk("len3 a_waddr[2]", (qaw.size() > 2) ? qaw[2] : -1, 2);
        chk("len3 a_raddr[1]", (qar.size() > 1) ? qar[1] : -1, 0);

        // Reset in the middle of a clear
        send_cfg(4, 12, 'h7);
        cyc(5);
        chk("mid-clear clr_active", clr_active, 1);
        chk("mid-clear c", int'(b_waddr), 5);
        chk("mid-clear a_we", a_we, 0);
        rst_n = 1'b0;
        cyc(1);
        chk("post-rst a_we", a_we, 0);
        chk("post-rst b_we", b_we, 0);
        chk("post-rst clr_active", clr_active, 0);
        chk("post-rst cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;
        s_valid = 1'b1;
        cyc(1);
        s_valid = 1'b0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
